// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage_lsu_pkg                                                |
// | Brief   : Shared constants, FSM encoding and helpers for the MEM-stage LSU |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mem_stage_lsu_pkg;

    localparam int LSU_ADDR_W_DEF  = 7;
    localparam int LSU_DATA_W_DEF  = 32;
    localparam int LSU_TIMEOUT_DEF = 64;
    localparam int LSU_STALL_W     = 16;

    typedef logic [1:0] lsu_state_t;

    localparam logic [1:0] c_LSU_IDLE = 2'd0;
    localparam logic [1:0] c_LSU_WAIT = 2'd1;
    localparam logic [1:0] c_LSU_DONE = 2'd2;

    // Saturating increment for the stall performance counter.
    function automatic logic [LSU_STALL_W-1:0] sat_inc(input logic [LSU_STALL_W-1:0] v);
        if (v == {LSU_STALL_W{1'b1}}) begin
            return v;
        end
        return v + {{(LSU_STALL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : mem_stage_lsu_pkg
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage_lsu_if / mem_stage_lsu_mem_if                          |
// | Brief   : Core-side and memory-side bundles of the MEM-stage LSU           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_stage_lsu_if
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W_DEF,
    parameter int DATA_W = LSU_DATA_W_DEF
) ();

    logic                   ls_valid;
    logic                   ls_we;
    logic [ADDR_W-1:0]      ls_addr;
    logic [DATA_W-1:0]      ls_wdata;
    logic                   ls_stall;
    logic                   ls_done;
    logic [DATA_W-1:0]      ls_rdata;
    logic                   ls_err;
    logic [LSU_STALL_W-1:0] stall_cnt;

    // The core issues lw/sw; the LSU answers with stall/done/data.
    modport master (
        output ls_valid, ls_we, ls_addr, ls_wdata,
        input  ls_stall, ls_done, ls_rdata, ls_err, stall_cnt
    );

    modport slave (
        input  ls_valid, ls_we, ls_addr, ls_wdata,
        output ls_stall, ls_done, ls_rdata, ls_err, stall_cnt
    );

endinterface : mem_stage_lsu_if

interface mem_stage_lsu_mem_if
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W_DEF,
    parameter int DATA_W = LSU_DATA_W_DEF
) ();

    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // The LSU drives requests; the data memory completes them with mem_ready.
    modport master (
        output mem_cen, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_cen, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface : mem_stage_lsu_mem_if
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage_lsu                                                    |
// | Brief   : Load/store unit stalling a single-cycle core over a              |
// |           variable-latency data memory handshake with timeout abort        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W  = LSU_ADDR_W_DEF,
    parameter int DATA_W  = LSU_DATA_W_DEF,
    parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_stage_lsu_if.slave     core,
    mem_stage_lsu_mem_if.master mem
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    lsu_state_t             r_state;
    logic                   r_cen;
    logic                   r_wen;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_done;
    logic                   r_err;
    logic [TO_W-1:0]        r_to_cnt;
    logic [LSU_STALL_W-1:0] r_stall_cnt;

    logic                   w_stall;
    logic                   w_to_expired;

    always_comb begin
        w_stall      = ((r_state == c_LSU_IDLE) && core.ls_valid) || (r_state == c_LSU_WAIT);
        w_to_expired = (r_to_cnt == c_TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_LSU_IDLE;
            r_cen    <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_LSU_IDLE: begin
                    if (core.ls_valid) begin
                        r_addr   <= core.ls_addr;
                        r_wdata  <= core.ls_wdata;
                        r_wen    <= core.ls_we;
                        r_cen    <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= c_LSU_WAIT;
                    end
                end
                c_LSU_WAIT: begin
                    // mem_ready takes priority over an expiring timeout in the same cycle.
                    if (mem.mem_ready) begin
                        if (!r_wen) begin
                            r_rdata <= mem.mem_rdata;
                        end
                        r_cen   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_LSU_DONE;
                    end else if (w_to_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cen   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_LSU_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                c_LSU_DONE: begin
                    // ls_valid still belongs to the retiring instruction here.
                    r_state <= c_LSU_IDLE;
                end
                default: begin
                    r_state <= c_LSU_IDLE;
                    r_cen   <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign core.ls_stall  = w_stall;
    assign core.ls_done   = r_done;
    assign core.ls_rdata  = r_rdata;
    assign core.ls_err    = r_err;
    assign core.stall_cnt = r_stall_cnt;

    assign mem.mem_cen    = r_cen;
    assign mem.mem_wen    = r_wen;
    assign mem.mem_addr   = r_addr;
    assign mem.mem_wdata  = r_wdata;

endmodule : mem_stage_lsu
`default_nettype wire
